mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Purpose: sits downstream of I_cache and D_cache; merges both 128-bit block requests onto one slow-memory port.

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 proc_reset_n  input  1  reset, synchronous, active-low.
REQ-003 ic_read  input  1  I-cache block read request, level, held until ic_ready.
REQ-004 ic_addr  input  28  I-cache block address.
REQ-005 ic_rdata  output  128  block returned to I-cache, valid while ic_ready=1.
REQ-006 ic_ready  output  1  one-cycle completion pulse to I-cache.
REQ-007 dc_read  input  1  D-cache block read request, level.
REQ-008 dc_write  input  1  D-cache block write-back request, level.
REQ-009 dc_addr  input  28  D-cache block address.
REQ-010 dc_wdata  input  128  D-cache write-back data.
REQ-011 dc_rdata  output  128  block returned to D-cache, valid while dc_ready=1.
REQ-012 dc_ready  output  1  one-cycle completion pulse to D-cache.
REQ-013 mem_read  output  1  memory read strobe, registered.
REQ-014 mem_write  output  1  memory write strobe, registered.
REQ-015 mem_addr  output  28  memory block address, registered.
REQ-016 mem_wdata  output  128  memory write data, registered.
REQ-017 mem_rdata  input  128  memory read data, valid with mem_ready.
REQ-018 mem_ready  input  1  memory completion pulse.

Function
REQ-019 FSM states: IDLE, GRANT_I, GRANT_D, RESP; one transaction in flight at a time.
REQ-020 IDLE: dc request = dc_read|dc_write; if exactly one client requests, grant it; neither -> stay IDLE.
REQ-021 Both request in IDLE: round-robin; grant the client not granted last; last-grant flag resets to "I", so the first contention goes to D.
REQ-022 On grant at edge n: latch addr/command/wdata into mem_addr/mem_wdata; set mem_read or mem_write at cycle n+1; enter GRANT_I/GRANT_D.
REQ-023 dc_read and dc_write both high: treat as write; mem_read stays 0.
REQ-024 I-cache grant: mem_read=1, mem_write=0, mem_wdata unchanged.
REQ-025 GRANT_x: hold mem_read/mem_write/mem_addr/mem_wdata stable; ignore both clients' request lines until mem_ready=1.
REQ-026 mem_ready=1 in GRANT_x at cycle m: capture mem_rdata into the granted client's rdata register; clear mem_read/mem_write at m+1; enter RESP.
REQ-027 RESP (cycle m+1): granted client's ready=1 for exactly one cycle; other client's ready=0; update last-grant flag; next state IDLE.
REQ-028 Requests seen during RESP are ignored; clients drop request the cycle after ready, so IDLE at m+2 sees fresh requests only.
REQ-029 Back-to-back: request sampled in IDLE at m+2 gives a memory strobe at m+3; minimum gap between transactions is 2 idle strobe cycles.
REQ-030 Write transaction: on completion, dc_ready pulses; dc_rdata is loaded with mem_rdata regardless, and the client ignores it.
REQ-031 ic_rdata/dc_rdata hold their last value outside the ready cycle.
REQ-032 mem_ready outside GRANT_x is ignored; no state change.
REQ-033 No timeout: GRANT_x waits indefinitely for mem_ready.

Reset
REQ-034 proc_reset_n=0 at an edge: state IDLE, last-grant="I", mem_read=mem_write=0, mem_addr=0, mem_wdata=0, ic/dc_rdata=0, ic/dc_ready=0.
REQ-035 Reset mid-transaction abandons it; no ready pulse is issued; a later mem_ready is ignored per REQ-032.

Verification
REQ-036 I-only read: ic_read, ic_addr=0x0000010; memory returns 0xAA..AA after 5 cycles -> mem_read=1 with mem_addr=0x0000010 next cycle; ic_ready one cycle after mem_ready with ic_rdata=0xAA..AA.
REQ-037 Contention: ic_read and dc_read in the same IDLE cycle after reset -> D served first; I served next, starting 2 cycles after dc_ready.
REQ-038 Write-back then read: dc_write addr 0x1234567 wdata 0x55..55, then dc_read addr 0x0ABCDEF -> mem_write with correct addr/data, dc_ready, then mem_read 0x0ABCDEF, dc_ready with returned data.
REQ-039 Stale request: client keeps its request high during the RESP cycle -> no duplicate memory transaction.
REQ-040 Reset mid GRANT_D: proc_reset_n low for 1 cycle -> strobes 0 next cycle, no dc_ready, later mem_ready ignored.
REQ-041 Illegal dc_read=dc_write=1 -> mem_write=1, mem_read=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the I-cache and D-cache 128-bit block requests onto a
// single slow-memory port. One memory transaction is in flight at a time. When
// both clients request together, a round-robin flag picks between them.
//
// Handshakes:
//   Client side: ic_read / dc_read / dc_write are level requests. Each is held
//   with its address and data until the client's ready pulse. ic_ready and
//   dc_ready are registered one-cycle pulses. The matching rdata is valid
//   during that pulse and holds its value afterwards.
//   Memory side: mem_read / mem_write stay asserted, with mem_addr and
//   mem_wdata stable, until memory returns a one-cycle mem_ready pulse. That
//   same pulse qualifies mem_rdata. mem_ready is ignored unless a grant is
//   active.
module mem_arbiter (
   input  logic         clk,
   input  logic         proc_reset_n,
   input  logic         ic_read,
   input  logic [27:0]  ic_addr,
   output logic [127:0] ic_rdata,
   output logic         ic_ready,
   input  logic         dc_read,
   input  logic         dc_write,
   input  logic [27:0]  dc_addr,
   input  logic [127:0] dc_wdata,
   output logic [127:0] dc_rdata,
   output logic         dc_ready,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT_I = 2'd1,
      S_GRANT_D = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t state;
   // 1 when the most recently completed transaction belonged to the D-cache.
   logic   last_grant_d;
   // Records which client owns the transaction that is currently in RESP.
   logic   resp_d;

   logic   dc_req;
   logic   grant_i;
   logic   grant_d;

   // Arbitration decision for IDLE: a lone requester wins. Under contention,
   // the client that was not served last wins.
   always_comb begin
      dc_req  = dc_read | dc_write;
      grant_d = dc_req & (~ic_read | ~last_grant_d);
      grant_i = ic_read & (~dc_req | last_grant_d);
   end

   assign dbg_state = state;

   // Transaction FSM. All memory-side strobes and client-side outputs are
   // registered here.
   always_ff @(posedge clk) begin
      if (!proc_reset_n) begin
         state        <= S_IDLE;
         last_grant_d <= 1'b0;
         resp_d       <= 1'b0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         mem_addr     <= 28'h0;
         mem_wdata    <= 128'h0;
         ic_rdata     <= 128'h0;
         dc_rdata     <= 128'h0;
         ic_ready     <= 1'b0;
         dc_ready     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_d) begin
                  // A simultaneous read+write from the D-cache is treated as a write-back.
                  mem_addr  <= dc_addr;
                  mem_wdata <= dc_wdata;
                  mem_write <= dc_write;
                  mem_read  <= ~dc_write;
                  state     <= S_GRANT_D;
               end else if (grant_i) begin
                  // The I-cache only reads, so mem_wdata keeps its last value.
                  mem_addr  <= ic_addr;
                  mem_read  <= 1'b1;
                  mem_write <= 1'b0;
                  state     <= S_GRANT_I;
               end
            end

            S_GRANT_I: begin
               // Strobes, address and data hold until memory completes; there is no timeout.
               if (mem_ready) begin
                  ic_rdata  <= mem_rdata;
                  ic_ready  <= 1'b1;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  resp_d    <= 1'b0;
                  state     <= S_RESP;
               end
            end

            S_GRANT_D: begin
               // Write-backs also load dc_rdata; the D-cache disregards it.
               if (mem_ready) begin
                  dc_rdata  <= mem_rdata;
                  dc_ready  <= 1'b1;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  resp_d    <= 1'b1;
                  state     <= S_RESP;
               end
            end

            S_RESP: begin
               // Requests sampled here are still the ones that were just served, so they are ignored.
               ic_ready     <= 1'b0;
               dc_ready     <= 1'b0;
               last_grant_d <= resp_d;
               state        <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
